// File: rtl/noc_axis_credit_tx.sv
// AXI-Stream to credit-based NoC injection stage: per-VC credit counters, packet-level VC lock.
// Optional statistics counters are enabled by defining NOC_AXIS_CREDIT_TX_STATS_EN.
module noc_axis_credit_tx #(
  parameter int unsigned N             = 8,
  parameter int unsigned D_W           = 32,
  parameter int unsigned A_W           = $clog2(N) + 1,
  parameter int unsigned VC_W          = 2,
  parameter int unsigned TID_W         = 8,
  parameter int unsigned TDEST_W       = 8,
  parameter int unsigned VC_FIFO_DEPTH = 32,
  parameter int unsigned CREDIT_W      = $clog2(VC_FIFO_DEPTH) + 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic [D_W-1:0]             s_axis_tdata,
  input  logic [TDEST_W-1:0]         s_axis_tdest,
  input  logic [TID_W-1:0]           s_axis_tid,
  input  logic                       s_axis_tlast,
  output logic                       o_noc_valid,
  output logic [D_W-1:0]             o_noc_data,
  output logic [A_W-1:0]             o_noc_addr,
  output logic [VC_W-1:0]            o_noc_vc,
  output logic                       o_noc_last,
  input  logic [VC_W-1:0]            i_noc_credit,
  output logic [VC_W*CREDIT_W-1:0]   o_credit_count,
  output logic                       o_credit_err
`ifdef NOC_AXIS_CREDIT_TX_STATS_EN
  ,
  output logic [31:0]                o_stall_cycles,
  output logic [31:0]                o_flit_count
`endif
);

  localparam int unsigned SEL_W = (VC_W > 1) ? $clog2(VC_W) : 1;
  localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(VC_FIFO_DEPTH - 1);
  localparam logic [CREDIT_W-1:0] CREDIT_ONE = CREDIT_W'(1);

  typedef enum logic {
    IDLE,
    IN_PKT
  } state_e;

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    lock_q, lock_d;
  logic [SEL_W-1:0]    sel;
  logic [CREDIT_W-1:0] credit_q [VC_W];
  logic [CREDIT_W-1:0] credit_d [VC_W];
  logic [VC_W-1:0]     dec_vec;
  logic                err_q, err_d;
  logic                accept;

  logic                valid_q;
  logic [D_W-1:0]      data_q;
  logic [A_W-1:0]      addr_q;
  logic [VC_W-1:0]     vc_q;
  logic                last_q;

  // Upper TDEST bits beyond the NoC address are intentionally dropped.
  logic unused_tdest;
  assign unused_tdest = ^s_axis_tdest;

  always_comb begin
    sel = SEL_W'(s_axis_tid % TID_W'(VC_W));
    if (state_q == IN_PKT) begin
      sel = lock_q;
    end
  end

  assign s_axis_tready = i_rst_n & (credit_q[sel] != '0);
  assign accept        = s_axis_tvalid & s_axis_tready;

  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    if (accept) begin
      if (s_axis_tlast) begin
        state_d = IDLE;
      end else begin
        state_d = IN_PKT;
        lock_d  = sel;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
    end
  end

  always_comb begin
    dec_vec = '0;
    for (int unsigned v = 0; v < VC_W; v++) begin
      dec_vec[v] = accept && (sel == SEL_W'(v));
    end
  end

  // A simultaneous consume and return on one VC cancels out, even at the full count.
  always_comb begin
    err_d = err_q;
    for (int unsigned v = 0; v < VC_W; v++) begin
      credit_d[v] = credit_q[v];
      if (dec_vec[v] && !i_noc_credit[v]) begin
        credit_d[v] = credit_q[v] - CREDIT_ONE;
      end else if (i_noc_credit[v] && !dec_vec[v]) begin
        if (credit_q[v] == CREDIT_MAX) begin
          err_d = 1'b1;
        end else begin
          credit_d[v] = credit_q[v] + CREDIT_ONE;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int unsigned v = 0; v < VC_W; v++) begin
        credit_q[v] <= CREDIT_MAX;
      end
      err_q <= 1'b0;
    end else begin
      for (int unsigned v = 0; v < VC_W; v++) begin
        credit_q[v] <= credit_d[v];
      end
      err_q <= err_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
      vc_q    <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= accept;
      if (accept) begin
        data_q <= s_axis_tdata;
        addr_q <= s_axis_tdest[A_W-1:0];
        vc_q   <= VC_W'(1) << sel;
        last_q <= s_axis_tlast;
      end
    end
  end

  always_comb begin
    o_credit_count = '0;
    for (int unsigned v = 0; v < VC_W; v++) begin
      o_credit_count[v*CREDIT_W +: CREDIT_W] = credit_q[v];
    end
  end

  assign o_noc_valid  = valid_q;
  assign o_noc_data   = data_q;
  assign o_noc_addr   = addr_q;
  assign o_noc_vc     = vc_q;
  assign o_noc_last   = last_q;
  assign o_credit_err = err_q;

`ifdef NOC_AXIS_CREDIT_TX_STATS_EN
  logic [31:0] stall_q;
  logic [31:0] flit_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      stall_q <= '0;
      flit_q  <= '0;
    end else begin
      if (s_axis_tvalid && !s_axis_tready && (stall_q != '1)) begin
        stall_q <= stall_q + 32'd1;
      end
      if (accept && (flit_q != '1)) begin
        flit_q <= flit_q + 32'd1;
      end
    end
  end

  assign o_stall_cycles = stall_q;
  assign o_flit_count   = flit_q;
`endif

endmodule
